// File: rtl/syzygy_dac_pkg.sv
// Shared encodings and helpers for the SYZYGY DAC wave player.
package syzygy_dac_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned BURST_W = 16;

  typedef enum logic [MODE_W-1:0] {
    MODE_LOOP    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_BURST   = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Offset-binary zero: 1 << (data_w-1), returned wide and cast by the caller.
  function automatic logic [31:0] midscale(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/syzygy_dac_wave_ram.sv
// Per-channel sample store: simple dual-port, two banks, registered read.
module syzygy_dac_wave_ram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W:0]   rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/syzygy_dac_wave_player.sv
// Multi-channel double-buffered waveform player feeding a SYZYGY DAC pod.
module syzygy_dac_wave_player
  import syzygy_dac_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NUM_CH = 2,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [MODE_W-1:0]        mode,
  input  logic [ADDR_W:0]          play_len,
  input  logic [BURST_W-1:0]       burst_cnt,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     swap_req,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH*DATA_W-1:0] dac_data_o,
  output logic                     dac_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     act_bank
);

  localparam logic [DATA_W-1:0] MID     = DATA_W'(midscale(DATA_W));
  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    last_q, last_d;
  mode_e                mode_q, mode_d;
  logic [BURST_W-1:0]   pass_q, pass_d;
  logic                 pend_q, pend_d;
  logic                 bank_q, bank_d;
  logic                 drain_q, drain_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 dac_valid_q, dac_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_CH*DATA_W-1:0] dac_q, dac_d;

  logic                 wrap_c;
  logic                 swap_c;
  logic                 end_pass_c;
  logic                 wr_bank_c;
  mode_e                mode_in_c;

  assign wrap_c     = (addr_q == last_q);
  assign swap_c     = pend_q | swap_req;
  assign mode_in_c  = mode_e'(mode);
  assign end_pass_c = wrap_c && ((mode_q == MODE_BURST) ? (pass_q == BURST_W'(1))
                                                        : (mode_q != MODE_LOOP));
  // Writes follow the bank that will be idle after this edge's swap decision.
  assign wr_bank_c  = ~bank_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_PLAY;
      ST_PLAY:  if (stop || end_pass_c) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    addr_d      = addr_q;
    last_d      = last_q;
    mode_d      = mode_q;
    pass_d      = pass_q;
    pend_d      = pend_q;
    bank_d      = bank_q;
    drain_d     = 1'b0;
    rd_vld_d    = (state_q == ST_PLAY);
    dac_valid_d = rd_vld_q;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (swap_c) bank_d = ~bank_q;
        if (start) begin
          addr_d = '0;
          last_d = ((play_len == '0) || (play_len > DEPTH)) ? '1
                                                            : ADDR_W'(play_len - LEN_ONE);
          mode_d = (mode_in_c == MODE_RSVD) ? MODE_ONESHOT : mode_in_c;
          pass_d = (burst_cnt == '0) ? BURST_W'(1) : burst_cnt;
        end
      end
      ST_PLAY: begin
        addr_d = wrap_c ? '0 : addr_q + ADDR_W'(1);
        pend_d = swap_c;
        if (wrap_c) begin
          if (swap_c) begin
            bank_d = ~bank_q;
            pend_d = 1'b0;
          end
          if (mode_q == MODE_BURST) pass_d = pass_q - BURST_W'(1);
        end
      end
      ST_DRAIN: begin
        pend_d  = swap_c;
        drain_d = ~drain_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      last_q      <= '0;
      mode_q      <= MODE_LOOP;
      pass_q      <= '0;
      pend_q      <= 1'b0;
      bank_q      <= 1'b0;
      drain_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      dac_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dac_q       <= {NUM_CH{MID}};
    end else begin
      addr_q      <= addr_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      pass_q      <= pass_d;
      pend_q      <= pend_d;
      bank_q      <= bank_d;
      drain_q     <= drain_d;
      rd_vld_q    <= rd_vld_d;
      dac_valid_q <= dac_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dac_q       <= dac_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_W-1:0] rd_data;

    syzygy_dac_wave_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk_i     (clk),
      .wr_en_i   (wr_en && (wr_ch == CH_W'(k))),
      .wr_addr_i ({wr_bank_c, wr_addr}),
      .wr_data_i (wr_data),
      .rd_addr_i ({bank_q, addr_q}),
      .rd_data_o (rd_data)
    );

    // Channel enable gates at the output register, not at the RAM.
    assign dac_d[k*DATA_W +: DATA_W] = (rd_vld_q && ch_en[k]) ? rd_data : MID;
  end

  assign dac_data_o = dac_q;
  assign dac_valid  = dac_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign act_bank   = bank_q;

endmodule

// File: tb/tb_syzygy_dac_wave_player.sv
// Directed bench for syzygy_dac_wave_player with hand-derived expected samples.
module tb_syzygy_dac_wave_player;

  localparam int unsigned DW  = 12;
  localparam int unsigned AW  = 10;
  localparam int unsigned NCH = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [0:0]        wr_ch;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [1:0]        mode;
  logic [AW:0]       play_len;
  logic [15:0]       burst_cnt;
  logic              start, stop, swap_req;
  logic [NCH-1:0]    ch_en;
  logic [NCH*DW-1:0] dac_data_o;
  logic              dac_valid, busy, done, act_bank;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] cap0[$];
  logic [DW-1:0] cap1[$];

  always #5 clk = ~clk;

  syzygy_dac_wave_player #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .mode(mode), .play_len(play_len), .burst_cnt(burst_cnt),
    .start(start), .stop(stop), .swap_req(swap_req), .ch_en(ch_en),
    .dac_data_o(dac_data_o), .dac_valid(dac_valid), .busy(busy), .done(done),
    .act_bank(act_bank)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int a, input int d);
    wr_en = 1'b1; wr_ch = 1'(ch); wr_addr = AW'(a); wr_data = DW'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic go(input int m, input int len, input int bc);
    mode = 2'(m); play_len = (AW+1)'(len); burst_cnt = 16'(bc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Cycle c = ticks after the start edge; stops two cycles after done.
  task automatic run_capture(input int max_cyc, input int start_poke,
                             output int first_v, output int done_at, output int n_done);
    first_v = -1; done_at = -1; n_done = 0;
    cap0.delete(); cap1.delete();
    for (int c = 1; c <= max_cyc; c++) begin
      start = (c == start_poke);
      tick();
      if (dac_valid) begin
        if (first_v < 0) first_v = c;
        cap0.push_back(dac_data_o[DW-1:0]);
        cap1.push_back(dac_data_o[2*DW-1:DW]);
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (done_at > 0 && c >= done_at + 2) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int fv, da, nd, bad0, bad1, n;
    reset_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
    mode = '0; play_len = '0; burst_cnt = '0; start = 1'b0; stop = 1'b0;
    swap_req = 1'b0; ch_en = 2'b11;
    repeat (3) tick();
    chk("rst valid", 32'(dac_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst bank", 32'(act_bank), 0);
    chk("rst data", 32'(dac_data_o), 32'h800800);
    reset_n = 1'b1;
    tick();

    // ONESHOT from bank1 after an IDLE swap
    for (int a = 0; a < 8; a++) begin
      wr(0, a, a);
      wr(1, a, 12'hFFF - a);
    end
    swap();
    chk("idle swap bank", 32'(act_bank), 1);
    go(1, 4, 0);
    chk("oneshot busy", 32'(busy), 1);
    run_capture(20, 0, fv, da, nd);
    chk("oneshot first", 32'(fv), 2);
    chk("oneshot done_at", 32'(da), 6);
    chk("oneshot n_done", 32'(nd), 1);
    chk("oneshot count", 32'(cap0.size()), 4);
    n = (cap0.size() < 4) ? cap0.size() : 4;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("oneshot ch0[%0d]", i), 32'(cap0[i]), i);
      chk($sformatf("oneshot ch1[%0d]", i), 32'(cap1[i]), 32'hFFF - i);
    end
    chk("oneshot busy end", 32'(busy), 0);

    // BURST x2 with an ignored start mid-run
    go(2, 3, 2);
    run_capture(30, 3, fv, da, nd);
    chk("burst2 count", 32'(cap0.size()), 6);
    chk("burst2 done_at", 32'(da), 8);
    chk("burst2 n_done", 32'(nd), 1);
    n = (cap0.size() < 6) ? cap0.size() : 6;
    for (int i = 0; i < n; i++)
      chk($sformatf("burst2 ch0[%0d]", i), 32'(cap0[i]), i % 3);

    go(2, 3, 0);
    run_capture(30, 0, fv, da, nd);
    chk("burst0 count", 32'(cap0.size()), 3);
    chk("burst0 done_at", 32'(da), 5);

    go(3, 2, 0);
    run_capture(30, 0, fv, da, nd);
    chk("mode3 count", 32'(cap0.size()), 2);
    chk("mode3 done_at", 32'(da), 4);

    // LOOP with swap requested mid-pass
    for (int a = 0; a < 8; a++) wr(0, a, 12'h100 + a);
    swap();
    chk("loop pre bank", 32'(act_bank), 0);
    for (int a = 0; a < 8; a++) wr(0, a, 12'h200 + a);
    go(0, 8, 0);
    cap0.delete();
    for (int c = 1; c <= 22; c++) begin
      swap_req = (c == 3);
      tick();
      if (dac_valid) cap0.push_back(dac_data_o[DW-1:0]);
    end
    swap_req = 1'b0;
    chk("loopswap count", 32'(cap0.size()), 21);
    n = (cap0.size() < 21) ? cap0.size() : 21;
    for (int i = 0; i < n; i++)
      chk($sformatf("loopswap ch0[%0d]", i), 32'(cap0[i]),
          (i < 8) ? (32'h100 + i) : (32'h200 + (i % 8)));
    chk("loopswap bank", 32'(act_bank), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int c = 0; c < 10 && !done; c++) tick();
    chk("loopswap done", 32'(done), 1);

    // stop while address 5 is issued
    go(0, 8, 0);
    repeat (5) tick();
    chk("stop pre ch0", 32'(dac_data_o[DW-1:0]), 32'h203);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop s4 valid", 32'(dac_valid), 1);
    chk("stop s4 ch0", 32'(dac_data_o[DW-1:0]), 32'h204);
    tick();
    chk("stop s5 ch0", 32'(dac_data_o[DW-1:0]), 32'h205);
    chk("stop s5 busy", 32'(busy), 1);
    tick();
    chk("stop end valid", 32'(dac_valid), 0);
    chk("stop end data", 32'(dac_data_o), 32'h800800);
    chk("stop end done", 32'(done), 1);
    chk("stop end busy", 32'(busy), 0);
    tick();
    chk("stop done pulse", 32'(done), 0);

    // ch_en = 10 with play_len = 0 -> full 1024-sample pass
    for (int a = 0; a < 1024; a++) wr(1, a, a ^ 12'hA5A);
    swap();
    ch_en = 2'b10;
    go(1, 0, 0);
    run_capture(1100, 0, fv, da, nd);
    ch_en = 2'b11;
    chk("full count", 32'(cap1.size()), 1024);
    chk("full done_at", 32'(da), 1026);
    bad0 = 0; bad1 = 0;
    for (int i = 0; i < cap1.size(); i++) begin
      if (cap0[i] !== 12'h800) bad0++;
      if (cap1[i] !== DW'(i ^ 12'hA5A)) bad1++;
    end
    chk("full ch0 midscale errs", 32'(bad0), 0);
    chk("full ch1 sample errs", 32'(bad1), 0);

    // async reset mid LOOP run at address 3
    swap();
    chk("prereset bank", 32'(act_bank), 1);
    go(0, 8, 0);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst valid", 32'(dac_valid), 0);
    chk("arst data", 32'(dac_data_o), 32'h800800);
    chk("arst busy", 32'(busy), 0);
    chk("arst bank", 32'(act_bank), 0);
    tick();
    chk("arst hold done", 32'(done), 0);
    chk("arst hold valid", 32'(dac_valid), 0);
    reset_n = 1'b1;
    tick();
    chk("post rst done", 32'(done), 0);
    go(1, 4, 0);
    run_capture(20, 0, fv, da, nd);
    chk("replay count", 32'(cap0.size()), 4);
    chk("replay first", 32'(fv), 2);
    n = (cap0.size() < 4) ? cap0.size() : 4;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("replay ch0[%0d]", i), 32'(cap0[i]), 32'h100 + i);
      chk($sformatf("replay ch1[%0d]", i), 32'(cap1[i]), 32'(i ^ 12'hA5A));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
